vec_mem_seq: RTL and testbench

Vector memory sequencer between the CVP14 execute stage and the staticram port. It turns one vector load/store request into VLEN consecutive single-word SRAM accesses. Load data is returned to the vector register file one element per cycle; store data is fetched from the register file one element per cycle. It owns the SRAM Addr/RD/WR/DataOut pins whenever it is busy.

---
 rtl/vec_mem_seq_if.sv | 36 +++
 rtl/vec_mem_seq.sv | 73 +++++++
 tb/tb_vec_mem_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/vec_mem_seq_if.sv
// vec_mem_seq_if: request, register-file, SRAM and writeback signals of the vector memory sequencer.
interface vec_mem_seq_if #(
    parameter int VLEN = 16,
    parameter int DW   = 16,
    parameter int AW   = 16
);
    localparam int IW = $clog2(VLEN);
    logic          req_valid;
    logic          req_ready;
    logic          req_store;
    logic [AW-1:0] req_base;
    logic [2:0]    req_vreg;
    logic [2:0]    st_rd_vreg;
    logic [IW-1:0] st_rd_idx;
    logic [DW-1:0] st_data;
    logic [AW-1:0] Addr;
    logic          RD;
    logic          WR;
    logic [DW-1:0] DataOut;
    logic [DW-1:0] DataIn;
    logic          wb_valid;
    logic [2:0]    wb_vreg;
    logic [IW-1:0] wb_idx;
    logic [DW-1:0] wb_data;
    logic          done;
    modport master (
        input  req_valid, req_store, req_base, req_vreg, st_data, DataIn,
        output req_ready, st_rd_vreg, st_rd_idx, Addr, RD, WR, DataOut,
               wb_valid, wb_vreg, wb_idx, wb_data, done
    );
    modport slave (
        output req_valid, req_store, req_base, req_vreg, st_data, DataIn,
        input  req_ready, st_rd_vreg, st_rd_idx, Addr, RD, WR, DataOut,
               wb_valid, wb_vreg, wb_idx, wb_data, done
    );
endinterface

// File: rtl/vec_mem_seq.sv
// vec_mem_seq: expands one vector load/store into VLEN single-word SRAM accesses.
module vec_mem_seq #(
    parameter int VLEN   = 16,
    parameter int DW     = 16,
    parameter int AW     = 16,
    parameter int RD_LAT = 1
) (
    input logic           Clk1,
    input logic           Reset,
    vec_mem_seq_if.master m
);
    localparam int IW = $clog2(VLEN);
    localparam int CW = IW + 1;
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, DRAIN = 3'd2, STORE = 3'd3, DONE = 3'd4;
    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic [AW-1:0]     base;
    logic [2:0]        vreg;
    logic [RD_LAT-1:0] pv;
    logic [IW-1:0]     pidx [RD_LAT];
    logic              ld, st, last, wb_last;
    assign ld      = state == LOAD;
    assign st      = state == STORE;
    assign last    = cnt == CW'(VLEN - 1);
    assign wb_last = pv[RD_LAT-1] && pidx[RD_LAT-1] == IW'(VLEN - 1);
    // pv/pidx shadow the SRAM read latency so each writeback carries its element index
    always_ff @(posedge Clk1 or posedge Reset)
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            base  <= '0;
            vreg  <= '0;
            pv    <= '0;
            for (int i = 0; i < RD_LAT; i++) pidx[i] <= '0;
        end else begin
            pv[0]   <= ld;
            pidx[0] <= cnt[IW-1:0];
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i]   <= pv[i-1];
                pidx[i] <= pidx[i-1];
            end
            case (state)
                IDLE: if (m.req_valid) begin
                    state <= m.req_store ? STORE : LOAD;
                    base  <= m.req_base;
                    vreg  <= m.req_vreg;
                    cnt   <= '0;
                end
                LOAD: begin
                    cnt <= cnt + CW'(1);
                    if (last) state <= DRAIN;
                end
                STORE: begin
                    cnt <= cnt + CW'(1);
                    if (last) state <= DONE;
                end
                DRAIN: if (wb_last) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    assign m.req_ready  = state == IDLE;
    assign m.RD         = ld;
    assign m.WR         = st;
    assign m.Addr       = (ld || st) ? base + AW'(cnt) : '0;
    assign m.st_rd_vreg = vreg;
    assign m.st_rd_idx  = st ? cnt[IW-1:0] : '0;
    assign m.DataOut    = st ? m.st_data : '0;
    assign m.wb_valid   = pv[RD_LAT-1];
    assign m.wb_vreg    = m.wb_valid ? vreg : '0;
    assign m.wb_idx     = m.wb_valid ? pidx[RD_LAT-1] : '0;
    assign m.wb_data    = m.wb_valid ? m.DataIn : '0;
    assign m.done       = state == DONE;
endmodule

// File: tb/tb_vec_mem_seq.sv
// tb_vec_mem_seq: directed checks of vec_mem_seq with RD_LAT=1 and RD_LAT=3 instances.
module tb_vec_mem_seq;
    localparam int VLEN = 16;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_store, sel3;
    logic [15:0] req_base;
    logic [2:0]  req_vreg;
    logic [15:0] rf [8][VLEN];
    logic [15:0] mem [65536];
    bit          wf [65536];
    logic [15:0] rp1, r3a, r3b, r3c;
    int          n, nf;
    always #5 clk = ~clk;
    vec_mem_seq_if #(.VLEN(VLEN)) i1 ();
    vec_mem_seq_if #(.VLEN(VLEN)) i3 ();
    vec_mem_seq #(.VLEN(VLEN), .RD_LAT(1)) d1 (.Clk1(clk), .Reset(rst), .m(i1));
    vec_mem_seq #(.VLEN(VLEN), .RD_LAT(3)) d3 (.Clk1(clk), .Reset(rst), .m(i3));
    assign i1.req_valid = req_valid & ~sel3;
    assign i3.req_valid = req_valid & sel3;
    assign i1.req_store = req_store;
    assign i3.req_store = req_store;
    assign i1.req_base  = req_base;
    assign i3.req_base  = req_base;
    assign i1.req_vreg  = req_vreg;
    assign i3.req_vreg  = req_vreg;
    assign i1.st_data   = rf[i1.st_rd_vreg][i1.st_rd_idx];
    assign i3.st_data   = rf[i3.st_rd_vreg][i3.st_rd_idx];
    assign i1.DataIn    = rp1;
    assign i3.DataIn    = r3c;
    function automatic logic [15:0] init_f(input logic [15:0] a);
        logic [15:0] w;
        w = a + 16'd8;
        if (a >= 16'h0100 && a < 16'h0110) return a + 16'h0F00;
        if (w < 16'd16) return 16'h7700 + w;
        return 16'hDEAD;
    endfunction
    function automatic logic [15:0] rdm(input logic [15:0] a);
        return wf[a] ? mem[a] : init_f(a);
    endfunction
    always @(posedge clk) begin
        if (i1.WR) begin
            mem[i1.Addr] <= i1.DataOut;
            wf[i1.Addr]  <= 1'b1;
        end
        rp1 <= rdm(i1.Addr);
        r3a <= rdm(i3.Addr);
        r3b <= r3a;
        r3c <= r3b;
    end
    wire        o_rd    = sel3 ? i3.RD : i1.RD;
    wire        o_wr    = sel3 ? i3.WR : i1.WR;
    wire [15:0] o_addr  = sel3 ? i3.Addr : i1.Addr;
    wire [15:0] o_dout  = sel3 ? i3.DataOut : i1.DataOut;
    wire        o_wbv   = sel3 ? i3.wb_valid : i1.wb_valid;
    wire [2:0]  o_wbr   = sel3 ? i3.wb_vreg : i1.wb_vreg;
    wire [3:0]  o_wbi   = sel3 ? i3.wb_idx : i1.wb_idx;
    wire [15:0] o_wbd   = sel3 ? i3.wb_data : i1.wb_data;
    wire        o_done  = sel3 ? i3.done : i1.done;
    wire        o_ready = sel3 ? i3.req_ready : i1.req_ready;
    wire [3:0]  o_sidx  = sel3 ? i3.st_rd_idx : i1.st_rd_idx;
    wire [2:0]  o_svr   = sel3 ? i3.st_rd_vreg : i1.st_rd_vreg;
    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            nf++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask
    task automatic reset_check(input string tag);
        chk({tag, ".rd"}, 0, o_rd, 0);
        chk({tag, ".wr"}, 0, o_wr, 0);
        chk({tag, ".addr"}, 0, o_addr, 0);
        chk({tag, ".dout"}, 0, o_dout, 0);
        chk({tag, ".wbv"}, 0, o_wbv, 0);
        chk({tag, ".wbr"}, 0, o_wbr, 0);
        chk({tag, ".wbi"}, 0, o_wbi, 0);
        chk({tag, ".wbd"}, 0, o_wbd, 0);
        chk({tag, ".done"}, 0, o_done, 0);
        chk({tag, ".sidx"}, 0, o_sidx, 0);
        chk({tag, ".svr"}, 0, o_svr, 0);
        chk({tag, ".ready"}, 0, o_ready, 1);
    endtask
    task automatic go(input logic s, input logic [15:0] b, input logic [2:0] v);
        chk("go.ready", 0, o_ready, 1);
        req_valid = 1'b1;
        req_store = s;
        req_base  = b;
        req_vreg  = v;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask
    task automatic load_check(input logic [15:0] b, input logic [2:0] v, input int lat,
                              input logic [15:0] d0, input logic [15:0] nb);
        for (int c = 0; c <= VLEN + lat + 1; c++) begin
            logic a, w;
            logic [15:0] ea;
            a  = c < VLEN;
            w  = c >= lat && c < VLEN + lat;
            ea = b + 16'(c);
            chk("ld.rd", c, o_rd, a);
            chk("ld.wr", c, o_wr, 0);
            chk("ld.addr", c, o_addr, a ? ea : 16'h0);
            chk("ld.wbv", c, o_wbv, w);
            chk("ld.wbi", c, o_wbi, w ? 4'(c - lat) : 4'h0);
            chk("ld.wbd", c, o_wbd, w ? d0 + 16'(c - lat) : 16'h0);
            chk("ld.wbr", c, o_wbr, w ? v : 3'h0);
            chk("ld.done", c, o_done, c == VLEN + lat);
            chk("ld.ready", c, o_ready, c == VLEN + lat + 1);
            if (c == 5) req_base = nb;
            if (c < VLEN + lat + 1) begin
                @(posedge clk); #1;
            end
        end
    endtask
    task automatic store_check(input logic [15:0] b, input logic [2:0] v, input logic [15:0] d0);
        for (int c = 0; c <= VLEN + 1; c++) begin
            logic a;
            a = c < VLEN;
            chk("st.wr", c, o_wr, a);
            chk("st.rd", c, o_rd, 0);
            chk("st.addr", c, o_addr, a ? b + 16'(c) : 16'h0);
            chk("st.dout", c, o_dout, a ? d0 + 16'(c) : 16'h0);
            chk("st.sidx", c, o_sidx, a ? 4'(c) : 4'h0);
            chk("st.svr", c, o_svr, v);
            chk("st.wbv", c, o_wbv, 0);
            chk("st.done", c, o_done, c == VLEN);
            chk("st.ready", c, o_ready, c == VLEN + 1);
            if (c < VLEN + 1) begin
                @(posedge clk); #1;
            end
        end
    endtask
    initial begin
        n = 0;
        nf = 0;
        rst = 1'b1;
        sel3 = 1'b0;
        req_valid = 1'b0;
        req_store = 1'b0;
        req_base = '0;
        req_vreg = '0;
        for (int v = 0; v < 8; v++)
            for (int i = 0; i < VLEN; i++)
                rf[v][i] = 16'(v * 16'h1111 + i);
        for (int i = 0; i < VLEN; i++) rf[5][i] = 16'hA5A0 + 16'(i);
        #12;
        reset_check("rst0");
        rst = 1'b0;
        @(posedge clk); #1;
        go(1'b0, 16'h0100, 3'd3);
        load_check(16'h0100, 3'd3, 1, 16'h1000, 16'h0100);
        go(1'b1, 16'h0200, 3'd5);
        store_check(16'h0200, 3'd5, 16'hA5A0);
        go(1'b0, 16'h0200, 3'd6);
        load_check(16'h0200, 3'd6, 1, 16'hA5A0, 16'h0200);
        // request held high with base changed mid-load; the second accept lands on the wrapping base
        req_valid = 1'b1;
        req_store = 1'b0;
        req_base  = 16'h0100;
        req_vreg  = 3'd3;
        @(posedge clk); #1;
        load_check(16'h0100, 3'd3, 1, 16'h1000, 16'hFFF8);
        @(posedge clk); #1;
        req_valid = 1'b0;
        load_check(16'hFFF8, 3'd3, 1, 16'h7700, 16'hFFF8);
        go(1'b0, 16'h0100, 3'd3);
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("mid.rd", 6, o_rd, 1);
        #2 rst = 1'b1;
        #1 reset_check("rst_mid");
        #1 rst = 1'b0;
        for (int c = 0; c < VLEN + 4; c++) begin
            @(posedge clk); #1;
            chk("post.wbv", c, o_wbv, 0);
            chk("post.done", c, o_done, 0);
            chk("post.ready", c, o_ready, 1);
        end
        go(1'b0, 16'h0100, 3'd3);
        load_check(16'h0100, 3'd3, 1, 16'h1000, 16'h0100);
        sel3 = 1'b1;
        #1;
        go(1'b0, 16'h0100, 3'd2);
        load_check(16'h0100, 3'd2, 3, 16'h1000, 16'h0100);
        $display("End of test - %0d assertions evaluated, %0d failures", n, nf);
        $finish;
    end
endmodule
